// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_bus_arbiter
// Purpose  : Two-requester arbiter for the GPIO peripheral register port.
//            Define GPIO_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [DATA_W-1:0] rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  logic   r_win;
  logic   r_we;
  logic   w_win;

`ifdef GPIO_ARB_FIXED_PRIO_EN
  assign w_win = req_i[1] & ~req_i[0];
`else
  // r_last holds the index granted most recently; a tie goes to the other one.
  logic r_last;

  assign w_win = req_i[1] & (~req_i[0] | ~r_last);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last <= 1'b1;
    end else if (r_state == S_IDLE && |req_i) begin
      r_last <= w_win;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      gnt_o    <= 2'b00;
      rvalid_o <= 2'b00;
      rdata_o  <= '0;
      wen_o    <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
      raddr_o  <= '0;
    end else begin
      gnt_o    <= 2'b00;
      rvalid_o <= 2'b00;
      wen_o    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_i) begin
            r_win   <= w_win;
            r_we    <= we_i[w_win];
            gnt_o   <= w_win ? 2'b10 : 2'b01;
            r_state <= S_ISSUE;
            if (we_i[w_win]) begin
              wen_o   <= 1'b1;
              waddr_o <= w_win ? addr1_i : addr0_i;
              wdata_o <= w_win ? wdata1_i : wdata0_i;
            end else begin
              raddr_o <= w_win ? addr1_i : addr0_i;
            end
          end
        end
        S_ISSUE: begin
          r_state <= r_we ? S_IDLE : S_RWAIT;
        end
        S_RWAIT: begin
          // Peripheral data is valid this cycle, one cycle after raddr_o.
          rdata_o  <= rdata_i;
          rvalid_o <= r_win ? 2'b10 : 2'b01;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_bus_arbiter
// Purpose  : Self-checking bench for gpio_bus_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef GPIO_ARB_FIXED_PRIO_EN
  localparam logic [1:0] c_tie_b = 2'b01;
  localparam bit         c_rr    = 1'b0;
`else
  localparam logic [1:0] c_tie_b = 2'b10;
  localparam bit         c_rr    = 1'b1;
`endif

  logic              clk_i   = 1'b0;
  logic              rst_n_i = 1'b1;
  logic [1:0]        req_i   = '0;
  logic [1:0]        we_i    = '0;
  logic [ADDR_W-1:0] addr0_i = '0;
  logic [ADDR_W-1:0] addr1_i = '0;
  logic [DATA_W-1:0] wdata0_i = '0;
  logic [DATA_W-1:0] wdata1_i = '0;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              wen_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;
  logic [ADDR_W-1:0] raddr_o;
  logic [DATA_W-1:0] rdata_i = '0;

  gpio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .wen_o(wen_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .raddr_o(raddr_o), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] periph(input logic [ADDR_W-1:0] a);
    return a + 32'h5;
  endfunction

  // Registered peripheral: data for an address appears the cycle after it.
  always @(posedge clk_i) rdata_i <= periph(raddr_o);

  typedef struct {
    logic [1:0]        bits;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  typedef struct {
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [1:0]        exp_gnt;
  } vec_t;

  exp_t gq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mg, mr;
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      chk("exclusive", {(gnt_o == 2'b11), (rvalid_o == 2'b11), (|gnt_o && |rvalid_o)}, 0);
      if (|gnt_o || wen_o) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {gnt_o, wen_o}, 0);
        end else begin
          mg = gq.pop_front();
          chk("gnt_cycle", cyc, mg.cyc);
          chk("gnt_bits", gnt_o, mg.bits);
          chk("wen", wen_o, mg.wr);
          if (mg.wr) begin
            chk("waddr", waddr_o, mg.addr);
            chk("wdata", wdata_o, mg.data);
          end else begin
            chk("raddr", raddr_o, mg.addr);
          end
        end
      end
      if (|rvalid_o) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", rvalid_o, 0);
        end else begin
          mr = rq.pop_front();
          chk("rvalid_cycle", cyc, mr.cyc);
          chk("rvalid_bits", rvalid_o, mr.bits);
          chk("rdata", rdata_o, mr.data);
        end
      end
      if (gq.size() != 0 && cyc > gq[0].cyc) begin
        chk("missing_gnt", cyc, gq[0].cyc);
        gq.delete(0);
      end
      if (rq.size() != 0 && cyc > rq[0].cyc) begin
        chk("missing_rvalid", cyc, rq[0].cyc);
        rq.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec [8];
    vec_t v;
    exp_t e, r;
    logic win;
    int c;

    vec[0] = '{2'b01, 2'b01, 32'h4,   32'h0,        32'hA,  32'h0,        2'b01};
    vec[1] = '{2'b10, 2'b00, 32'h0,   32'h0,        32'h0,  32'h0,        2'b10};
    vec[2] = '{2'b11, 2'b11, 32'h100, 32'h200,      32'h11, 32'h22,       2'b01};
    vec[3] = '{2'b11, 2'b00, 32'h30,  32'h40,       32'h0,  32'h0,        c_tie_b};
    vec[4] = '{2'b11, 2'b01, 32'h50,  32'h60,       32'h55, 32'h66,       2'b01};
    vec[5] = '{2'b01, 2'b00, 32'h64,  32'h0,        32'h0,  32'h0,        2'b01};
    vec[6] = '{2'b11, 2'b10, 32'h70,  32'h7C,       32'h77, 32'hDEAD,     c_tie_b};
    vec[7] = '{2'b10, 2'b10, 32'h0,   32'hFFFFFFFC, 32'h0,  32'hFFFFFFFF, 2'b10};

    #2 rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {gnt_o, rvalid_o, wen_o, rdata_o, waddr_o, wdata_o, raddr_o}, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) begin
      v = vec[i];
      win = v.exp_gnt[1];
      req_i = v.req; we_i = v.we;
      addr0_i = v.a0; addr1_i = v.a1; wdata0_i = v.d0; wdata1_i = v.d1;
      e.bits = v.exp_gnt; e.wr = v.we[win];
      e.addr = win ? v.a1 : v.a0; e.data = win ? v.d1 : v.d0; e.cyc = cyc + 1;
      gq.push_back(e);
      if (!e.wr) begin
        r.bits = v.exp_gnt; r.wr = 1'b0; r.addr = e.addr; r.data = periph(e.addr); r.cyc = cyc + 3;
        rq.push_back(r);
      end
      @(negedge clk_i);
      req_i = 2'b00;
      repeat (e.wr ? 1 : 3) @(negedge clk_i);
    end

    // Withdrawal: requester 1 asks during a requester 0 read, then gives up.
    c = cyc;
    req_i = 2'b01; we_i = 2'b00; addr0_i = 32'h84;
    e = '{2'b01, 1'b0, 32'h84, 32'h0, c + 1}; gq.push_back(e);
    r = '{2'b01, 1'b0, 32'h84, periph(32'h84), c + 3}; rq.push_back(r);
    @(negedge clk_i);
    req_i = 2'b10; we_i = 2'b10; addr1_i = 32'h90; wdata1_i = 32'h99;
    @(negedge clk_i);
    @(negedge clk_i);
    req_i = 2'b00;
    repeat (3) begin
      @(negedge clk_i);
      chk("withdraw_quiet", {gnt_o, wen_o}, 0);
    end

    // Mixed: pending read completes before the competing write is issued.
    c = cyc;
    req_i = 2'b01; we_i = 2'b00; addr0_i = 32'hC0;
    e = '{2'b01, 1'b0, 32'hC0, 32'h0, c + 1}; gq.push_back(e);
    r = '{2'b01, 1'b0, 32'hC0, periph(32'hC0), c + 3}; rq.push_back(r);
    @(negedge clk_i);
    req_i = 2'b10; we_i = 2'b10; addr1_i = 32'hA0; wdata1_i = 32'hBEEF;
    e = '{2'b10, 1'b1, 32'hA0, 32'hBEEF, c + 5}; gq.push_back(e);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (gnt_o[1]) break;
    end
    req_i = 2'b00;
    @(negedge clk_i);

    // Asynchronous reset while a read sits in RWAIT.
    c = cyc;
    req_i = 2'b10; we_i = 2'b00; addr1_i = 32'h8;
    e = '{2'b10, 1'b0, 32'h8, 32'h0, c + 1}; gq.push_back(e);
    @(negedge clk_i);
    req_i = 2'b00;
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 chk("async_reset_outputs", {gnt_o, rvalid_o, wen_o, rdata_o, waddr_o, wdata_o, raddr_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("no_rvalid_after_reset", rvalid_o, 0);
    end

    // Continuous contention, all writes; pointer is fresh from reset.
    c = cyc;
    req_i = 2'b11; we_i = 2'b11;
    addr0_i = 32'h10; wdata0_i = 32'hAA; addr1_i = 32'h20; wdata1_i = 32'hBB;
    for (int k = 0; k < 8; k++) begin
      e.bits = (c_rr && k[0]) ? 2'b10 : 2'b01;
      e.wr = 1'b1;
      e.addr = e.bits[1] ? 32'h20 : 32'h10;
      e.data = e.bits[1] ? 32'hBB : 32'hAA;
      e.cyc = c + 1 + 2 * k;
      gq.push_back(e);
    end
    repeat (15) @(negedge clk_i);
    req_i = 2'b00;
    repeat (3) @(negedge clk_i);

    chk("gnt_queue_drained", gq.size(), 0);
    chk("rvalid_queue_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
